barrett_reduce_64b_reg: RTL and testbench

//  Final Barrett stage of the 64b modular multiplier; consumes the q_hat*m product from multiplier_128b_reg.

---
 rtl/barrett_reduce_64b_reg_pkg.sv | 22 ++
 rtl/barrett_reduce_64b_reg_cond_sub.sv | 47 ++++
 rtl/barrett_reduce_64b_reg.sv | 114 +++++++++++
 tb/tb_barrett_reduce_64b_reg.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrett_reduce_64b_reg_pkg.sv
// Shared widths and types for the final Barrett reduction stage of the
// 64b modular multiplier.
package barrett_reduce_64b_reg_pkg;

   localparam int MOD_W         = 64;          // modulus / result width
   localparam int WIDE_W        = 128;         // a*b product width
   localparam int QM_W          = 2 * WIDE_W;  // q_hat*m product width from multiplier_128b_reg
   localparam int RED_W         = MOD_W + 2;   // working width: true remainder is < 3m < 2^66
   localparam int X_DLY_DEFAULT = 7;           // q_hat*m path latency, shared with the 128b multiplier

   // One slot of the x delay line: operand bits that matter plus its valid tag
   typedef struct packed {
      logic             valid;
      logic [RED_W-1:0] data;
   } red_entry_t;

   // Zero-extend the modulus to the working width for unsigned compares
   function automatic logic [RED_W-1:0] zext_mod(input logic [MOD_W-1:0] m);
      return {{(RED_W - MOD_W){1'b0}}, m};
   endfunction

endpackage

// File: rtl/barrett_reduce_64b_reg_cond_sub.sv
// Registered conditional subtract of the modulus over RED_W bits.
// result = (data >= m) ? data - m : data, with the valid tag carried alongside.
// result_ge flags that the value was still >= m after this subtraction.
module barrett_cond_sub_reg
   import barrett_reduce_64b_reg_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             valid,
   input  logic [RED_W-1:0] data,
   input  logic [MOD_W-1:0] modulus,
   output logic [RED_W-1:0] result,
   output logic             result_valid,
   output logic             result_ge
);

   logic [RED_W-1:0] mod_ext;
   logic [RED_W-1:0] diff;
   logic             ge;
   logic             ge_after;

   assign mod_ext  = zext_mod(modulus);
   assign diff     = data - mod_ext;
   assign ge       = (data >= mod_ext);
   // Only meaningful when the subtraction is taken; otherwise diff has wrapped
   assign ge_after = ge && (diff >= mod_ext);

   // Stage register: subtract when ge, hold on !en, zero on clear/reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result       <= '0;
         result_valid <= 1'b0;
         result_ge    <= 1'b0;
      end else if (clr) begin
         result       <= '0;
         result_valid <= 1'b0;
         result_ge    <= 1'b0;
      end else if (en) begin
         result       <= ge ? diff : data;
         result_valid <= valid;
         result_ge    <= ge_after;
      end
   end

endmodule

// File: rtl/barrett_reduce_64b_reg.sv
// Final Barrett stage: delays x = a*b to meet q_hat*m, forms r = x - q_hat*m
// over 66 bits, then applies two registered conditional subtractions of m.
// Validity is tracked here because the multiplier chain does not carry it.
module barrett_reduce_64b_reg
   import barrett_reduce_64b_reg_pkg::*;
#(
   parameter int X_DLY = X_DLY_DEFAULT
) (
   input  logic              iClk,
   input  logic              iRstN,
   input  logic              iEn,
   input  logic              iClr,
   input  logic              iValid,
   input  logic [WIDE_W-1:0] iX,
   input  logic [QM_W-1:0]   iQM,
   input  logic [MOD_W-1:0]  iMod,
   output logic [MOD_W-1:0]  oData,
   output logic              oValid,
   output logic              oErr
);

   red_entry_t       head;
   red_entry_t       tail;
   logic [RED_W-1:0] r0;
   logic             v1;
   logic [RED_W-1:0] r1;
   logic             v2;
   logic [RED_W-1:0] r2;
   logic             v3;
   logic             err;
   logic             s2_ge_unused;
   logic             unused_bits;

   assign head = {iValid, iX[RED_W-1:0]};

   // x delay line: X_DLY enabled-cycle stages so the tail meets its q_hat*m
   for (genvar gi = 0; gi < X_DLY; gi++) begin : g_dly
      red_entry_t prev;
      red_entry_t stage;

      if (gi == 0) begin : g_first
         assign prev = head;
      end else begin : g_link
         assign prev = g_dly[gi-1].stage;
      end

      // One delay slot, shifting only while the shared enable is high
      always_ff @(posedge iClk or negedge iRstN) begin
         if (!iRstN) begin
            stage <= '0;
         end else if (iClr) begin
            stage <= '0;
         end else if (iEn) begin
            stage <= prev;
         end
      end
   end

   if (X_DLY == 0) begin : g_no_dly
      assign tail = head;
   end else begin : g_tail
      assign tail = g_dly[X_DLY-1].stage;
   end

   // S1: raw remainder; wraps mod 2^66 by design since the true value is < 3m
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r0 <= '0;
         v1 <= 1'b0;
      end else if (iClr) begin
         r0 <= '0;
         v1 <= 1'b0;
      end else if (iEn) begin
         r0 <= tail.data - iQM[RED_W-1:0];
         v1 <= tail.valid;
      end
   end

   // S2: first conditional subtraction; its ge flag has no consumer
   barrett_cond_sub_reg u_s2 (
      .clk          (iClk),
      .rst_n        (iRstN),
      .en           (iEn),
      .clr          (iClr),
      .valid        (v1),
      .data         (r0),
      .modulus      (iMod),
      .result       (r1),
      .result_valid (v2),
      .result_ge    (s2_ge_unused)
   );

   // S3: second conditional subtraction; still >= m afterwards means bad operands
   barrett_cond_sub_reg u_s3 (
      .clk          (iClk),
      .rst_n        (iRstN),
      .en           (iEn),
      .clr          (iClr),
      .valid        (v2),
      .data         (r1),
      .modulus      (iMod),
      .result       (r2),
      .result_valid (v3),
      .result_ge    (err)
   );

   assign oData  = r2[MOD_W-1:0];
   assign oValid = v3;
   assign oErr   = err & v3;

   // Operand bits above the working width and the top result bits are ignored
   assign unused_bits = ^{iX[WIDE_W-1:RED_W], iQM[QM_W-1:RED_W], r2[RED_W-1:MOD_W], s2_ge_unused};

endmodule

// File: tb/tb_barrett_reduce_64b_reg.sv
// Self-checking bench for barrett_reduce_64b_reg: directed cases with literal
// expectations plus randomized traffic against a behavioural remainder model.
module tb_barrett_reduce_64b_reg;

   localparam int          X_DLY = 7;
   localparam int          LAT   = X_DLY + 3;
   localparam logic [63:0] M_DEF = 64'hFFFF_FFFF_0000_0001;

   typedef struct {
      bit          v;
      logic [63:0] data;
      bit          err;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic         clr;
   logic         valid;
   logic [127:0] x;
   logic [255:0] qm;
   logic [63:0]  m;
   logic [63:0]  o_data;
   logic         o_valid;
   logic         o_err;

   int           checks   = 0;
   int           failures = 0;
   bit           chk_on   = 1'b0;

   exp_t         pipe[$];
   logic [65:0]  qm_line[$];
   exp_t         exp_cur;

   int           lat;
   int           seen;
   logic [63:0]  m_list [4];
   logic [95:0]  r96;
   logic [67:0]  t;
   logic [65:0]  q;
   logic [127:0] xx;
   logic [255:0] junk;

   always #5 clk = ~clk;

   barrett_reduce_64b_reg #(.X_DLY(X_DLY)) dut (
      .iClk   (clk),
      .iRstN  (rst_n),
      .iEn    (en),
      .iClr   (clr),
      .iValid (valid),
      .iX     (x),
      .iQM    (qm),
      .iMod   (m),
      .oData  (o_data),
      .oValid (o_valid),
      .oErr   (o_err)
   );

   // Reference: d = x - q_hat*m mod 2^66; two subtractions reduce any d < 3m to d mod m,
   // anything larger leaves d - 2m and raises the error flag.
   function automatic exp_t ref_result(input bit v, input logic [127:0] xin,
                                       input logic [65:0] qin, input logic [63:0] mm);
      exp_t        e;
      logic [65:0] d;
      logic [67:0] d68;
      logic [67:0] m68;
      d   = xin[65:0] - qin;
      d68 = {2'b00, d};
      m68 = {4'b0000, mm};
      e.v = v;
      if (d68 < 3 * m68) begin
         e.data = 64'(d68 % m68);
         e.err  = 1'b0;
      end else begin
         e.data = 64'(d68 - 2 * m68);
         e.err  = 1'b1;
      end
      return e;
   endfunction

   task automatic model_clear();
      pipe.delete();
      qm_line.delete();
      for (int i = 0; i < LAT - 1; i++) pipe.push_back('{v: 1'b0, data: 64'd0, err: 1'b0});
      for (int i = 0; i < X_DLY; i++) qm_line.push_back(66'd0);
      exp_cur = '{v: 1'b0, data: 64'd0, err: 1'b0};
   endtask

   task automatic lit(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // One clock: drive at negedge, update model at posedge, return at next negedge.
   // q is the q_hat*m belonging to this slot; it reaches iQM X_DLY enabled cycles later.
   task automatic step(input bit e, input bit c, input bit v,
                       input logic [127:0] xin, input logic [65:0] qin);
      en    = e;
      clr   = c;
      valid = v;
      x     = xin;
      junk  = {8{$urandom()}};
      qm    = {junk[255:66], qm_line[0]};
      @(posedge clk);
      if (c) begin
         model_clear();
      end else if (e) begin
         qm_line.push_back(qin);
         void'(qm_line.pop_front());
         pipe.push_back(ref_result(v, xin, qin, m));
         exp_cur = pipe.pop_front();
      end
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, {$urandom(), $urandom(), $urandom(), $urandom()},
           66'({$urandom(), $urandom(), $urandom()}));
   endtask

   // Compare process: every cycle, outputs against the model
   always @(negedge clk) begin
      if (chk_on) begin
         checks++;
         if (o_valid !== exp_cur.v) begin
            failures++;
            $display("FAIL out_valid @%0t: got %0b want %0b", $time, o_valid, exp_cur.v);
         end
         checks++;
         if (o_err !== (exp_cur.v & exp_cur.err)) begin
            failures++;
            $display("FAIL out_err @%0t: got %0b want %0b", $time, o_err, exp_cur.v & exp_cur.err);
         end
         if (exp_cur.v) begin
            checks++;
            if (o_data !== exp_cur.data) begin
               failures++;
               $display("FAIL out_data @%0t: got %h want %h", $time, o_data, exp_cur.data);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; clr = 1'b0; valid = 1'b0;
      x = '0; qm = '0; m = M_DEF;
      model_clear();
      #1;
      lit("reset_data", o_data, 64'd0);
      lit("reset_valid", 64'(o_valid), 64'd0);
      lit("reset_err", 64'(o_err), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      chk_on = 1'b1;

      // 1: single op, latency 10
      step(1'b1, 1'b0, 1'b1, 128'd5, 66'd0);
      lat = 0;
      for (int i = 2; i <= 20 && lat == 0; i++) begin
         idle();
         if (o_valid) lat = i;
      end
      lit("t1_latency", 64'(lat), 64'd10);
      lit("t1_data", o_data, 64'd5);
      lit("t1_err", 64'(o_err), 64'd0);
      $display("txn t1 x=5 lat=%0d data=%h", lat, o_data);

      // 2: back-to-back m+3 and 2m+1
      step(1'b1, 1'b0, 1'b1, 128'(m) + 128'd3, 66'd0);
      step(1'b1, 1'b0, 1'b1, 128'(m) * 2 + 128'd1, 66'd0);
      for (int i = 3; i <= 9; i++) idle();
      lit("t2_early_valid", 64'(o_valid), 64'd0);
      idle();
      lit("t2_valid0", 64'(o_valid), 64'd1);
      lit("t2_data0", o_data, 64'd3);
      idle();
      lit("t2_valid1", 64'(o_valid), 64'd1);
      lit("t2_data1", o_data, 64'd1);
      lit("t2_err1", 64'(o_err), 64'd0);
      $display("txn t2 m+3,2m+1 last data=%h", o_data);

      // 3: 66-bit wrap of x - q_hat*m, iX bit 66 ignored
      step(1'b1, 1'b0, 1'b1, 128'h4_0000_0000_0000_0005, 66'h3_FFFF_FFFF_FFFF_FFFF);
      for (int i = 0; i < 9; i++) idle();
      lit("t3_valid", 64'(o_valid), 64'd1);
      lit("t3_data", o_data, 64'd6);
      lit("t3_err", 64'(o_err), 64'd0);
      $display("txn t3 wrap data=%h", o_data);

      // 4: x = 3m leaves m after two subtractions and flags an error
      step(1'b1, 1'b0, 1'b1, 128'(m) * 3, 66'd0);
      for (int i = 0; i < 9; i++) idle();
      lit("t4_valid", 64'(o_valid), 64'd1);
      lit("t4_data", o_data, m);
      lit("t4_err", 64'(o_err), 64'd1);
      $display("txn t4 3m data=%h err=%0b", o_data, o_err);

      // 5: three-cycle stall mid-flight stretches latency to 13
      step(1'b1, 1'b0, 1'b1, 128'(m) + 128'd3, 66'd0);
      for (int i = 2; i <= 4; i++) idle();
      for (int i = 5; i <= 7; i++) step(1'b0, 1'b0, 1'b1, 128'd99, 66'd7);
      lat = 0;
      for (int i = 8; i <= 30 && lat == 0; i++) begin
         idle();
         if (o_valid) lat = i;
      end
      lit("t5_latency", 64'(lat), 64'd13);
      lit("t5_data", o_data, 64'd3);
      $display("txn t5 stall lat=%0d data=%h", lat, o_data);

      // 6a: synchronous clear at cycle 4 discards the op
      step(1'b1, 1'b0, 1'b1, 128'd5, 66'd0);
      idle();
      idle();
      step(1'b0, 1'b1, 1'b1, 128'd5, 66'd0);
      lit("t6_clr_data", o_data, 64'd0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         idle();
         if (o_valid) seen++;
      end
      lit("t6_clr_valid_seen", 64'(seen), 64'd0);
      $display("txn t6a clear valid_seen=%0d", seen);

      // 6b: async reset with valid results in flight
      for (int i = 1; i <= 12; i++) step(1'b1, 1'b0, 1'b1, 128'(m) + 128'(i), 66'd0);
      lit("t6_pre_valid", 64'(o_valid), 64'd1);
      lit("t6_pre_data", o_data, 64'd3);
      #2;
      en = 1'b0; valid = 1'b0; rst_n = 1'b0;
      model_clear();
      #1;
      lit("t6_rst_data", o_data, 64'd0);
      lit("t6_rst_valid", 64'(o_valid), 64'd0);
      lit("t6_rst_err", 64'(o_err), 64'd0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      step(1'b1, 1'b0, 1'b1, 128'd5, 66'd0);
      lat = 0;
      for (int i = 2; i <= 20 && lat == 0; i++) begin
         idle();
         if (o_valid) lat = i;
      end
      lit("t6_post_latency", 64'(lat), 64'd10);
      lit("t6_post_data", o_data, 64'd5);
      $display("txn t6b reset then op lat=%0d data=%h", lat, o_data);

      // Random traffic over several moduli, with stalls and occasional clears
      m_list[0] = M_DEF;
      m_list[1] = {1'b1, 31'($urandom()), $urandom()};
      m_list[2] = 64'd97;
      m_list[3] = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 12; i++) idle();
         m = m_list[k];
         for (int n = 0; n < 400; n++) begin
            q   = 66'({$urandom(), $urandom(), $urandom()});
            r96 = {$urandom(), $urandom(), $urandom()};
            if ($urandom_range(3) == 0)
               t = 68'($urandom_range(2)) * {4'b0, m} + (($urandom_range(1) == 1) ? {4'b0, m} - 68'd1 : 68'd0);
            else
               t = 68'(r96 % (96'(m) * 3));
            xx = {$urandom(), $urandom(), $urandom(), $urandom()};
            xx[65:0] = q + t[65:0];
            step($urandom_range(4) != 0, $urandom_range(99) == 0, $urandom_range(1) == 1, xx, q);
            if (o_valid) $display("txn rnd m=%h data=%h err=%0b", m, o_data, o_err);
         end
      end
      for (int i = 0; i < 12; i++) idle();

      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
